// File: rtl/ad56x4_sequencer.sv
// Command sequencer for the three-chip AD56x4 serial driver: holds a shadow setpoint file,
// boots/reconfigures the DACs and schedules one "write and update" frame per dirty channel.
module ad56x4_sequencer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int GAP_CYCLES     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lb_write,
    input  logic [3:0]  lb_addr,
    input  logic [15:0] lb_data,
    input  logic        reconfig_req,
    input  logic        csb,
    output logic [2:0]  addr,
    output logic [15:0] voltage1,
    output logic [15:0] voltage2,
    output logic [15:0] voltage3,
    output logic        sdac_trig,
    output logic        reconfig,
    output logic        busy,
    output logic        timeout_err,
    output logic [15:0] update_cnt,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        SYNC      = 4'd0,
        REQ_RCFG  = 4'd1,
        CFG_TRIG  = 4'd2,
        IDLE      = 4'd3,
        LAUNCH    = 4'd4,
        TRIG      = 4'd5,
        WAIT_LOW  = 4'd6,
        WAIT_HIGH = 4'd7,
        GAP       = 4'd8
    } state_t;

    state_t      state;
    logic [15:0] shadow [0:2][0:3];
    logic [3:0]  dirty;
    logic        rcfg_pend;
    logic [1:0]  ptr;
    logic [1:0]  ch;
    logic        data_frame;
    logic [15:0] cnt;

    assign state_dbg = state;

    // First dirty channel at or after the round-robin pointer, wrapping 3 -> 0.
    function automatic logic [1:0] pick_channel(input logic [3:0] d, input logic [1:0] p);
        logic [1:0] idx;
        logic       found;
        pick_channel = p;
        found        = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = p + 2'(i);
            if (!found && d[idx]) begin
                pick_channel = idx;
                found        = 1'b1;
            end
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SYNC;
            addr        <= '0;
            voltage1    <= '0;
            voltage2    <= '0;
            voltage3    <= '0;
            sdac_trig   <= 1'b0;
            reconfig    <= 1'b0;
            busy        <= 1'b1;
            timeout_err <= 1'b0;
            update_cnt  <= '0;
            dirty       <= '0;
            rcfg_pend   <= 1'b0;
            ptr         <= '0;
            ch          <= '0;
            data_frame  <= 1'b0;
            cnt         <= '0;
            for (int d = 0; d < 3; d++) begin
                for (int c = 0; c < 4; c++) begin
                    shadow[d][c] <= '0;
                end
            end
        end else begin
            sdac_trig <= 1'b0;
            reconfig  <= 1'b0;
            case (state)
                SYNC: begin
                    if (csb) begin
                        state     <= REQ_RCFG;
                        reconfig  <= 1'b1;
                        rcfg_pend <= 1'b0;
                    end
                end
                REQ_RCFG: begin
                    state      <= CFG_TRIG;
                    sdac_trig  <= 1'b1;
                    data_frame <= 1'b0;
                end
                CFG_TRIG, TRIG: begin
                    state <= WAIT_LOW;
                    cnt   <= '0;
                end
                IDLE: begin
                    // Never start a frame while the driver still has csb low.
                    if (csb) begin
                        if (rcfg_pend) begin
                            state     <= REQ_RCFG;
                            reconfig  <= 1'b1;
                            rcfg_pend <= 1'b0;
                            busy      <= 1'b1;
                        end else if (|dirty) begin
                            ch    <= pick_channel(dirty, ptr);
                            state <= LAUNCH;
                            busy  <= 1'b1;
                        end
                    end
                end
                LAUNCH: begin
                    addr       <= {1'b0, ch};
                    voltage1   <= shadow[0][ch];
                    voltage2   <= shadow[1][ch];
                    voltage3   <= shadow[2][ch];
                    dirty[ch]  <= 1'b0;
                    ptr        <= ch + 2'd1;
                    data_frame <= 1'b1;
                    sdac_trig  <= 1'b1;
                    state      <= TRIG;
                end
                WAIT_LOW: begin
                    if (!csb) begin
                        state <= WAIT_HIGH;
                        cnt   <= '0;
                    end else if (cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= GAP;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                WAIT_HIGH: begin
                    if (csb) begin
                        if (data_frame) update_cnt <= update_cnt + 16'd1;
                        state <= GAP;
                        cnt   <= '0;
                    end else if (cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= SYNC;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (cnt == 16'(GAP_CYCLES - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= SYNC;
            endcase

            // Requests and writes land after the FSM so they win over same-cycle clears.
            if (reconfig_req) rcfg_pend <= 1'b1;
            if (lb_write) begin
                dirty[lb_addr[1:0]] <= 1'b1;
                for (int d = 0; d < 3; d++) begin
                    if (lb_addr[3:2] == 2'd3 || lb_addr[3:2] == 2'(d)) begin
                        shadow[d][lb_addr[1:0]] <= lb_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ad56x4_sequencer.sv
// Directed bench for ad56x4_sequencer with a simple driver model answering each trigger
// by pulling csb low 10 cycles later for 50 cycles.
module tb_ad56x4_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lb_write = 1'b0;
    logic [3:0]  lb_addr = '0;
    logic [15:0] lb_data = '0;
    logic        reconfig_req = 1'b0;
    logic        csb = 1'b1;
    logic [2:0]  addr;
    logic [15:0] voltage1, voltage2, voltage3;
    logic        sdac_trig, reconfig, busy, timeout_err;
    logic [15:0] update_cnt;
    logic [3:0]  state_dbg;

    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    logic model_on = 1'b1;
    logic manual_csb = 1'b1;
    logic bad_overlap = 1'b0;
    logic bad_trig_low = 1'b0;

    localparam logic [3:0] ST_SYNC   = 4'd0;
    localparam logic [3:0] ST_LAUNCH = 4'd4;

    ad56x4_sequencer dut (
        .clk(clk), .rst(rst), .lb_write(lb_write), .lb_addr(lb_addr), .lb_data(lb_data),
        .reconfig_req(reconfig_req), .csb(csb), .addr(addr), .voltage1(voltage1),
        .voltage2(voltage2), .voltage3(voltage3), .sdac_trig(sdac_trig), .reconfig(reconfig),
        .busy(busy), .timeout_err(timeout_err), .update_cnt(update_cnt), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Driver model: csb changes 2 time units after a rising edge, away from sampling.
    initial begin
        forever begin
            @(negedge clk);
            if (!model_on) begin
                csb = manual_csb;
            end else if (sdac_trig === 1'b1) begin
                repeat (10) @(posedge clk);
                #2 csb = 1'b0;
                repeat (50) @(posedge clk);
                #2 csb = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (sdac_trig === 1'b1 && reconfig === 1'b1) bad_overlap = 1'b1;
        if (sdac_trig === 1'b1 && csb === 1'b0) bad_trig_low = 1'b1;
    end

    task automatic lb_wr(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        lb_addr  = a;
        lb_data  = d;
        lb_write = 1'b1;
        @(negedge clk);
        lb_write = 1'b0;
    endtask

    task automatic wait_trig(output logic ok, output logic [66:0] frame);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!ok) begin
                if (sdac_trig === 1'b1) ok = 1'b1;
                else @(negedge clk);
            end
        end
        frame = {addr, voltage1, voltage2, voltage3};
    endtask

    task automatic wait_idle(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!ok) begin
                @(negedge clk);
                if (busy === 1'b0) ok = 1'b1;
            end
        end
    endtask

    task automatic wait_csb(input logic level, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!ok) begin
                @(negedge clk);
                if (csb === level) ok = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({addr, voltage1, voltage2, voltage3} !== 67'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", {addr, voltage1, voltage2, voltage3});
        end
        checks++; if ({sdac_trig, reconfig, busy, timeout_err} !== 4'b0010) begin
            errors++; $display("FAIL reset_flags: got %b expected 0010", {sdac_trig, reconfig, busy, timeout_err});
        end
        checks++; if (update_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_update_cnt: got %0d expected 0", update_cnt);
        end
    endtask

    task automatic test_boot();
        logic ok;
        int   n;
        rst = 1'b0;
        ok  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!ok) begin
                @(negedge clk);
                if (reconfig === 1'b1) ok = 1'b1;
            end
        end
        checks++; if (!ok) begin errors++; $display("FAIL boot_reconfig: got none expected pulse"); end
        @(negedge clk);
        checks++; if ({sdac_trig, reconfig} !== 2'b10) begin
            errors++; $display("FAIL boot_cfg_trig: got %b expected 10", {sdac_trig, reconfig});
        end
        wait_csb(1'b0, ok);
        if (ok) wait_csb(1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL boot_csb_frame: got no frame expected csb pulse"); end
        // One cycle to see csb high, then four GAP cycles.
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n != 5) begin errors++; $display("FAIL boot_busy_gap: got %0d cycles expected 5", n); end
        checks++; if (update_cnt !== 16'd0) begin
            errors++; $display("FAIL boot_update_cnt: got %0d expected 0", update_cnt);
        end
    endtask

    task automatic test_single_write();
        logic        ok;
        logic [66:0] fr;
        lb_wr(4'b0110, 16'h8001);
        wait_trig(ok, fr);
        checks++; if (!ok || fr !== {3'b010, 16'h0000, 16'h8001, 16'h0000}) begin
            errors++; $display("FAIL single_frame: got %h expected %h", fr, {3'b010, 16'h0000, 16'h8001, 16'h0000});
        end
        wait_idle(ok);
        exp_cnt++;
        checks++; if (!ok || update_cnt !== 16'(exp_cnt)) begin
            errors++; $display("FAIL single_update_cnt: got %0d expected %0d", update_cnt, exp_cnt);
        end
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_no_refire: got busy %b expected 0", busy); end
    endtask

    task automatic test_broadcast();
        logic        ok;
        logic [66:0] fr;
        lb_wr(4'b1100, 16'h1234);
        wait_trig(ok, fr);
        checks++; if (!ok || fr !== {3'd0, 16'h1234, 16'h1234, 16'h1234}) begin
            errors++; $display("FAIL broadcast_frame: got %h expected %h", fr, {3'd0, 16'h1234, 16'h1234, 16'h1234});
        end
        wait_idle(ok);
        exp_cnt++;
        checks++; if (!ok || update_cnt !== 16'(exp_cnt)) begin
            errors++; $display("FAIL broadcast_update_cnt: got %0d expected %0d", update_cnt, exp_cnt);
        end
    endtask

    task automatic test_round_robin();
        logic        ok;
        logic [66:0] fr;
        logic [66:0] exp_rr [3];
        exp_rr[0] = {3'd1, 16'h0000, 16'h1111, 16'h0000};
        exp_rr[1] = {3'd2, 16'h0000, 16'h8001, 16'h2222};
        exp_rr[2] = {3'd3, 16'h3333, 16'h0000, 16'h0300};
        // A channel-3 frame leaves the pointer at 0 before the three writes land.
        lb_wr(4'b1011, 16'h0300);
        wait_trig(ok, fr);
        checks++; if (!ok || fr !== {3'd3, 16'h0000, 16'h0000, 16'h0300}) begin
            errors++; $display("FAIL rr_prep_frame: got %h expected %h", fr, {3'd3, 16'h0000, 16'h0000, 16'h0300});
        end
        @(negedge clk); lb_addr = 4'b0011; lb_data = 16'h3333; lb_write = 1'b1;
        @(negedge clk); lb_addr = 4'b0101; lb_data = 16'h1111;
        @(negedge clk); lb_addr = 4'b1010; lb_data = 16'h2222;
        @(negedge clk); lb_write = 1'b0;
        wait_idle(ok);
        exp_cnt++;
        for (int k = 0; k < 3; k++) begin
            wait_trig(ok, fr);
            checks++; if (!ok || fr !== exp_rr[k]) begin
                errors++; $display("FAIL rr_frame%0d: got %h expected %h", k, fr, exp_rr[k]);
            end
            wait_idle(ok);
            exp_cnt++;
            checks++; if (!ok || update_cnt !== 16'(exp_cnt)) begin
                errors++; $display("FAIL rr_update_cnt%0d: got %0d expected %0d", k, update_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_write_during_send();
        logic        ok;
        logic [66:0] fr;
        // Rewrite while the frame is in WAIT_HIGH.
        lb_wr(4'b0000, 16'hA001);
        wait_trig(ok, fr);
        checks++; if (!ok || fr !== {3'd0, 16'hA001, 16'h1234, 16'h1234}) begin
            errors++; $display("FAIL wds_high_first: got %h expected %h", fr, {3'd0, 16'hA001, 16'h1234, 16'h1234});
        end
        wait_csb(1'b0, ok);
        lb_wr(4'b0000, 16'hA002);
        wait_idle(ok);
        exp_cnt++;
        wait_trig(ok, fr);
        checks++; if (!ok || fr !== {3'd0, 16'hA002, 16'h1234, 16'h1234}) begin
            errors++; $display("FAIL wds_high_second: got %h expected %h", fr, {3'd0, 16'hA002, 16'h1234, 16'h1234});
        end
        wait_idle(ok);
        exp_cnt++;
        // Rewrite in the LAUNCH cycle itself.
        lb_wr(4'b0000, 16'hB001);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!ok) begin
                if (state_dbg === ST_LAUNCH) ok = 1'b1;
                else @(negedge clk);
            end
        end
        checks++; if (!ok) begin errors++; $display("FAIL wds_launch_seen: got state %0d expected %0d", state_dbg, ST_LAUNCH); end
        lb_addr = 4'b0000; lb_data = 16'hB002; lb_write = 1'b1;
        @(negedge clk);
        lb_write = 1'b0;
        wait_trig(ok, fr);
        checks++; if (!ok || fr !== {3'd0, 16'hB001, 16'h1234, 16'h1234}) begin
            errors++; $display("FAIL wds_launch_first: got %h expected %h", fr, {3'd0, 16'hB001, 16'h1234, 16'h1234});
        end
        wait_idle(ok);
        exp_cnt++;
        wait_trig(ok, fr);
        checks++; if (!ok || fr !== {3'd0, 16'hB002, 16'h1234, 16'h1234}) begin
            errors++; $display("FAIL wds_launch_second: got %h expected %h", fr, {3'd0, 16'hB002, 16'h1234, 16'h1234});
        end
        wait_idle(ok);
        exp_cnt++;
        checks++; if (update_cnt !== 16'(exp_cnt)) begin
            errors++; $display("FAIL wds_update_cnt: got %0d expected %0d", update_cnt, exp_cnt);
        end
    endtask

    task automatic test_timeout_reconfig();
        logic        ok;
        logic        saw_rcfg, saw_trig;
        logic [66:0] fr;
        model_on   = 1'b0;
        manual_csb = 1'b1;
        lb_wr(4'b0001, 16'h0BAD);
        wait_trig(ok, fr);
        checks++; if (!ok || fr !== {3'd1, 16'h0BAD, 16'h1111, 16'h0000}) begin
            errors++; $display("FAIL to_frame: got %h expected %h", fr, {3'd1, 16'h0BAD, 16'h1111, 16'h0000});
        end
        repeat (200) @(negedge clk);
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early: got %b expected 0", timeout_err); end
        wait_idle(ok);
        checks++; if (!ok || timeout_err !== 1'b1) begin
            errors++; $display("FAIL to_flag: got %b expected 1", timeout_err);
        end
        checks++; if (update_cnt !== 16'(exp_cnt)) begin
            errors++; $display("FAIL to_update_cnt: got %0d expected %0d", update_cnt, exp_cnt);
        end
        model_on = 1'b1;
        lb_wr(4'b0010, 16'h0222);
        wait_trig(ok, fr);
        checks++; if (!ok || fr !== {3'd2, 16'h0222, 16'h8001, 16'h2222}) begin
            errors++; $display("FAIL rq_data_frame: got %h expected %h", fr, {3'd2, 16'h0222, 16'h8001, 16'h2222});
        end
        wait_csb(1'b0, ok);
        @(negedge clk);
        reconfig_req = 1'b1; lb_addr = 4'b0111; lb_data = 16'h0333; lb_write = 1'b1;
        @(negedge clk);
        reconfig_req = 1'b0; lb_write = 1'b0;
        wait_idle(ok);
        exp_cnt++;
        saw_rcfg = 1'b0;
        saw_trig = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!saw_rcfg && !saw_trig) begin
                @(negedge clk);
                saw_rcfg = reconfig;
                saw_trig = sdac_trig;
            end
        end
        checks++; if ({saw_rcfg, saw_trig} !== 2'b10) begin
            errors++; $display("FAIL rq_cfg_first: got rcfg/trig %b expected 10", {saw_rcfg, saw_trig});
        end
        wait_trig(ok, fr);
        wait_idle(ok);
        checks++; if (!ok || update_cnt !== 16'(exp_cnt)) begin
            errors++; $display("FAIL rq_cfg_no_count: got %0d expected %0d", update_cnt, exp_cnt);
        end
        wait_trig(ok, fr);
        checks++; if (!ok || fr !== {3'd3, 16'h3333, 16'h0333, 16'h0300}) begin
            errors++; $display("FAIL rq_dirty_after: got %h expected %h", fr, {3'd3, 16'h3333, 16'h0333, 16'h0300});
        end
        wait_idle(ok);
        exp_cnt++;
        checks++; if (update_cnt !== 16'(exp_cnt) || timeout_err !== 1'b1) begin
            errors++; $display("FAIL rq_final: got cnt %0d err %b expected cnt %0d err 1", update_cnt, timeout_err, exp_cnt);
        end
    endtask

    task automatic test_reset_csb_low();
        logic ok;
        logic saw;
        model_on   = 1'b0;
        manual_csb = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (reconfig === 1'b1) saw = 1'b1;
        end
        checks++; if (saw !== 1'b0 || state_dbg !== ST_SYNC || busy !== 1'b1) begin
            errors++; $display("FAIL rst_low_hold: got rcfg %b state %0d busy %b expected 0 0 1", saw, state_dbg, busy);
        end
        checks++; if (timeout_err !== 1'b0 || update_cnt !== 16'd0) begin
            errors++; $display("FAIL rst_low_clear: got err %b cnt %0d expected 0 0", timeout_err, update_cnt);
        end
        manual_csb = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!ok) begin
                @(negedge clk);
                if (reconfig === 1'b1) ok = 1'b1;
            end
        end
        model_on = 1'b1;
        checks++; if (!ok) begin errors++; $display("FAIL rst_low_reconfig: got none expected pulse"); end
        @(negedge clk);
        checks++; if ({sdac_trig, reconfig} !== 2'b10) begin
            errors++; $display("FAIL rst_low_cfg_trig: got %b expected 10", {sdac_trig, reconfig});
        end
        wait_idle(ok);
        checks++; if (!ok || update_cnt !== 16'd0) begin
            errors++; $display("FAIL rst_low_boot_done: got busy %b cnt %0d expected 0 0", busy, update_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_single_write();
        test_broadcast();
        test_round_robin();
        test_write_during_send();
        test_timeout_reconfig();
        test_reset_csb_low();
        checks++; if (bad_overlap !== 1'b0) begin
            errors++; $display("FAIL trig_rcfg_overlap: got %b expected 0", bad_overlap);
        end
        checks++; if (bad_trig_low !== 1'b0) begin
            errors++; $display("FAIL trig_while_csb_low: got %b expected 0", bad_trig_low);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
